// File: rtl/pipe_scoreboard.sv
// Register scoreboard for variable-latency execution units: per-register countdown to forwardability, RAW/WAW issue stall.
// Optional SCOREBOARD_PERF_EN adds saturating stall-cycle and issue counters.
module pipe_scoreboard #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned LAT_W    = 3,
  parameter int unsigned MAX_LAT  = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic [REG_AW-1:0]   issue_rs,
  input  logic [REG_AW-1:0]   issue_rt,
  input  logic                issue_rs_used,
  input  logic                issue_rt_used,
  input  logic [REG_AW-1:0]   issue_rd,
  input  logic                issue_wr,
  input  logic [LAT_W-1:0]    issue_lat,
  input  logic                flush,
  output logic                stall,
  output logic                issue_fire,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                idle
`ifdef SCOREBOARD_PERF_EN
  ,
  output logic [31:0]         stall_cycles,
  output logic [31:0]         issue_count
`endif
);

  localparam int unsigned ADDR_SPAN = 1 << REG_AW;

  logic [LAT_W-1:0]     r_cnt [1:NUM_REGS-1];
  logic [NUM_REGS-1:0]  w_busy;
  logic [ADDR_SPAN-1:0] w_busy_ext;
  logic [LAT_W-1:0]     w_lat_sat;
  logic                 w_stall;
  logic                 w_fire;

  // Register 0 never has an entry; out-of-range addresses read as not busy.
  always_comb begin
    w_busy = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      w_busy[i] = (r_cnt[i] != '0);
    end
    w_busy_ext = ADDR_SPAN'(w_busy);
  end

  assign w_stall = issue_valid &
                   ((issue_rs_used & w_busy_ext[issue_rs]) |
                    (issue_rt_used & w_busy_ext[issue_rt]) |
                    (issue_wr      & w_busy_ext[issue_rd]));
  assign w_fire    = issue_valid & ~w_stall & ~flush;
  assign w_lat_sat = (issue_lat > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : issue_lat;

  assign stall      = w_stall;
  assign issue_fire = w_fire;
  assign busy_vec   = w_busy;
  assign idle       = (w_busy == '0);

  // WAW stalling guarantees a load never lands on a live counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (w_fire && issue_wr && (issue_rd == REG_AW'(i))) begin
          r_cnt[i] <= w_lat_sat;
        end else if (r_cnt[i] != '0) begin
          r_cnt[i] <= r_cnt[i] - LAT_W'(1);
        end
      end
    end
  end

`ifdef SCOREBOARD_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_issue_count;

  // Saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_issue_count  <= '0;
    end else begin
      if (w_stall && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_fire && (r_issue_count != '1))   r_issue_count  <= r_issue_count + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign issue_count  = r_issue_count;
`endif

endmodule

// File: doc/pipe_scoreboard.md
# pipe_scoreboard

Parametrised register scoreboard for the pipelined MIPS core. It generalises the fixed two-stage hazard/forwarding pair to execution units with variable latency, such as a multi-cycle multiplier or a divider. It keeps a per-register countdown of cycles until each in-flight result is forwardable. It stalls issue on RAW and WAW hazards against any pending write, and sits beside the decode stage, driving the PC/IF_ID write-enable and bubble-mux controls.

## Interface
Parameters:
- NUM_REGS, 32, architectural register count; register 0 is hard-wired zero.
- REG_AW, 5, register address width; requires 2^REG_AW >= NUM_REGS.
- LAT_W, 3, latency counter width.
- MAX_LAT, 7, largest accepted latency; requires MAX_LAT <= 2^LAT_W-1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- issue_valid  in  1  decode presents an instruction this cycle.
- issue_rs, issue_rt  in  REG_AW  source register addresses.
- issue_rs_used, issue_rt_used  in  1  the source is actually read.
- issue_rd  in  REG_AW  destination register.
- issue_wr  in  1  the instruction writes issue_rd.
- issue_lat  in  LAT_W  cycles from issue until the result is forwardable.
- flush  in  1  branch/jump flush; the current issue is discarded.
- stall  out  1  hold PC and IF_ID, and insert an ID_EX bubble.
- issue_fire  out  1  issue accepted: issue_valid & ~stall & ~flush.
- busy_vec  out  NUM_REGS  bit i = register i has a pending write.
- idle  out  1  no register is busy.

## Operation
- State: cnt[i] (LAT_W bits) for i = 1..NUM_REGS-1. cnt[0] is constant 0. busy[i] = (cnt[i] != 0).
- stall is combinational: issue_valid & ((issue_rs_used & busy[issue_rs]) | (issue_rt_used & busy[issue_rt]) | (issue_wr & busy[issue_rd])).
- Any address equal to 0 never contributes to stall. Addresses >= NUM_REGS are treated as not busy.
- Per cycle, for each register i:
  - If issue_fire & issue_wr & issue_rd == i and i != 0: cnt[i] <= min(issue_lat, MAX_LAT).
  - Else if cnt[i] != 0: cnt[i] <= cnt[i] - 1.
  - Else cnt[i] holds.
- issue_lat == 0: the result is forwardable immediately; no entry is created.
- flush does not clear existing counters, because older in-flight writes still complete. flush only suppresses issue_fire.
- Simultaneous events:
  - A register at cnt == 1 is still busy this cycle, so a dependent instruction stalls exactly one more cycle.
  - A new issue is never allowed to overwrite a live counter, because WAW stalls it.
- Wrap-around: counters never underflow; decrement only when nonzero.

## Timing
- stall, issue_fire, busy_vec and idle are purely combinational from inputs and cnt. There are no registered outputs.
- Issue at edge N with lat L: busy from cycle N+1 through N+L. A dependent instruction fires at cycle N+L+1 at the earliest.
- Reset (async, any time, including mid-countdown): all cnt = 0, so busy_vec = 0, idle = 1, and stall = 0. issue_fire follows the inputs.
- Throughput: one issue per cycle when no hazard.

## Configuration
- SCOREBOARD_PERF_EN defined:
  - Adds output stall_cycles, 32 bits, which increments on every cycle with stall = 1 and saturates at 0xFFFFFFFF.
  - Adds output issue_count, 32 bits, which increments on every issue_fire and saturates.
  - Both counters are cleared by rst.
- SCOREBOARD_PERF_EN undefined: both ports and both counters are absent. Functional behaviour is identical.

## Test plan
- Reset mid-countdown:
  - Stimulus: issue rd=5, lat=4; assert rst one cycle later.
  - Required: busy_vec = 0 and idle = 1 immediately, before the next edge.
- RAW, multi-cycle:
  - Stimulus: issue rd=8, lat=3, then an instruction reading rs=8.
  - Required: stall = 1 for 3 cycles; issue_fire on the 4th cycle after the first issue.
- WAW, and register 0:
  - Stimulus: issue rd=3, lat=2, then issue_wr rd=3, lat=1.
  - Required: the second instruction stalls 2 cycles. A write to rd=0 with lat=7 leaves busy_vec = 0.
- Saturation:
  - Stimulus: issue_lat = 7 with MAX_LAT = 5.
  - Required: the dependent instruction stalls exactly 5 cycles.
- Flush:
  - Stimulus: issue rd=9 with flush = 1.
  - Required: issue_fire = 0 and register 9 not busy. A pending rd=4 entry still counts down normally.
- Perf (SCOREBOARD_PERF_EN defined):
  - Stimulus: the RAW scenario above.
  - Required: stall_cycles = 3 and issue_count = 2.
